stack_regs: RTL
===============

// Module: stack_regs
//
// PURPOSE
//   Parametrised LIFO stack for the J1 core's data and return stacks.
//   Generalises the plain stack register file: adds an internal stack pointer
//   and occupancy counter, so the core issues push/pop/replace instead of
//   raw addresses. Presents top (q) and next (nos) combinationally, and
//   detects overflow/underflow with selectable wrap or saturate policy.
//
// PARAMETERS
//   WIDTH  16  data width in bits
//   DEPTH  32  entries; power of two, 2..256
//   WRAP   0   1 = circular (push when full overwrites oldest); 0 = push when full is dropped
//
// PORTS
//   clk      in   1               clock, all state updates on posedge
//   reset_n  in   1               asynchronous active-low reset
//   push     in   1               push d (with pop: replace top)
//   pop      in   1               pop top (with push: replace top)
//   d        in   WIDTH           push/replace data
//   clr_err  in   1               clear sticky ovf/unf
//   q        out  WIDTH           top of stack; 0 when empty
//   nos      out  WIDTH           next on stack; 0 when depth < 2
//   depth    out  clog2(DEPTH+1)  occupancy, 0..DEPTH
//   empty    out  1               depth == 0
//   full     out  1               depth == DEPTH
//   ovf      out  1               sticky overflow flag
//   unf      out  1               sticky underflow flag
//
// BEHAVIOUR
//   - State: sp (clog2(DEPTH) bits, index of top), cnt, ovf, unf, mem[DEPTH].
//   - Reset (async, reset_n=0): sp=DEPTH-1, cnt=0, ovf=unf=0; mem not cleared.
//     Outputs during/after reset: q=0, nos=0, depth=0, empty=1, full=0, ovf=0, unf=0.
//   - q = (cnt!=0) ? mem[sp] : 0.
//   - nos = (cnt>=2) ? mem[sp-1 mod DEPTH] : 0.
//   - q and nos are combinational from state; an operation at edge N is visible right after edge N.
//   - Pointer arithmetic is modulo DEPTH (natural wrap of the sp width).
//   - Operation per cycle (sampled at posedge):
//     - idle (push=0, pop=0): no change.
//     - push, not full: sp<=sp+1; mem[sp+1]<=d; cnt<=cnt+1.
//     - push, full, WRAP=1: sp<=sp+1; mem[sp+1]<=d; cnt stays DEPTH (oldest lost); ovf<=1.
//     - push, full, WRAP=0: no state change except ovf<=1.
//     - pop, not empty: sp<=sp-1; cnt<=cnt-1; mem untouched.
//     - pop, empty: no state change except unf<=1 (both WRAP modes).
//     - push+pop, not empty: replace; mem[sp]<=d, sp and cnt unchanged, no flag.
//     - push+pop, empty: behaves as push into an empty stack (cnt=1, q=d), no flag.
//   - clr_err clears ovf and unf at the edge.
//     - A new ovf/unf event in the same cycle wins: that flag is set, the other is cleared.
//   - Reset mid-operation: the operation in flight is discarded; state returns to reset values immediately.
//   - No combinational path from push/pop/d to any output.
//
// TESTING
//   1. Reset then 3 pushes 0x1111,0x2222,0x3333 -> q=0x3333, nos=0x2222, depth=3; pop -> q=0x2222, nos=0x1111, depth=2.
//   2. Push DEPTH values 0..31 (WRAP=0) -> full=1, q=31; push 0xBEEF -> ovf=1, q=31, depth=32; pop 32x -> q sequence 31..0, then empty=1, q=0.
//   3. WRAP=1: push 0..32 (33 pushes) -> ovf=1, depth=32, q=32; pop 31x -> q=1; one more pop -> empty, q=0 (value 0 lost).
//   4. Pop on empty -> unf=1, depth=0, sp unchanged (next push lands, q=pushed value); clr_err -> unf=0; clr_err with simultaneous empty pop -> unf stays 1.
//   5. Replace: push 0xAAAA, push 0xBBBB, push+pop with d=0xCCCC -> q=0xCCCC, nos=0xAAAA, depth=2; push+pop on empty with d=0x5555 -> q=0x5555, depth=1.
//   6. Assert reset_n low mid-sequence (depth=5, ovf=1) between edges -> outputs go to reset values without a clock edge; first push after release -> q=d, depth=1.

Source files
------------

// File: rtl/stack_regs.sv
// LIFO stack with internal pointer and occupancy count.
// Top and next-on-stack are read combinationally from registered state.
module stack_regs #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int WRAP  = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             d,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             nos,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf,
  output logic                         unf
);

  localparam int SPW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);

  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   sp_inc, sp_dec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             we;
  logic [SPW-1:0]   wa;
  logic             is_empty, is_full;

  assign sp_inc   = sp_q + SPW'(1);
  assign sp_dec   = sp_q - SPW'(1);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    we    = 1'b0;
    wa    = sp_inc;
    unique case (1'b1)
      (push && pop): begin
        // Replace on a non-empty stack; on empty it degrades to a push.
        if (is_empty) begin
          sp_d  = sp_inc;
          cnt_d = CW'(1);
          we    = 1'b1;
          wa    = sp_inc;
        end else begin
          we    = 1'b1;
          wa    = sp_q;
        end
      end
      (push && !pop): begin
        if (!is_full) begin
          sp_d  = sp_inc;
          cnt_d = cnt_q + CW'(1);
          we    = 1'b1;
          wa    = sp_inc;
        end else begin
          ovf_d = 1'b1;
          if (WRAP != 0) begin
            sp_d = sp_inc;
            we   = 1'b1;
            wa   = sp_inc;
          end
        end
      end
      (!push && pop): begin
        if (!is_empty) begin
          sp_d  = sp_dec;
          cnt_d = cnt_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= SPW'(DEPTH-1);
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately not reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (we && reset_n) begin
      mem_q[wa] <= d;
    end
  end

  assign q     = is_empty ? '0 : mem_q[sp_q];
  assign nos   = (cnt_q >= CW'(2)) ? mem_q[sp_dec] : '0;
  assign depth = cnt_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
